// File: rtl/ibex_simd_mul_seq.sv
// ibex_simd_mul_seq: steps packed-SIMD lanes through one shared external
// 17x17 signed multiplier. Each product is folded into imd_val[0]. The result
// is then handed to ID with a valid/ready handshake.
// Optional feature macro: IBEX_SIMD_MUL_SAT_EN. When it is defined, signed
// DOT16 results are clamped to the 32-bit signed range and the clamp is
// reported on sat_o.
module ibex_simd_mul_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [1:0]  op_i,
  input  logic        signed_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] operand_rd_i,
  input  logic        ready_id_i,
  output logic [16:0] mul_op_a_o,
  output logic [16:0] mul_op_b_o,
  input  logic [33:0] mul_res_i,
  input  logic [33:0] imd_val_q_i [2],
  output logic [33:0] imd_val_d_o [2],
  output logic [1:0]  imd_val_we_o,
  output logic [31:0] result_o,
  output logic        valid_o,
  output logic        sat_o
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        is_dot8, is_mulh, last_lane;
  logic        we0, valid_int, drive_ops;
  logic [31:0] result_int;

  // Op 11 is not decoded, so it falls through to the DOT16 behaviour.
  assign is_dot8   = (op_i == 2'b01);
  assign is_mulh   = (op_i == 2'b10);
  assign last_lane = is_dot8 ? (cnt_q == 2'd3) : (cnt_q == 2'd1);

  // Lane slices, extended to 17 bits. In the unsigned case the top bit is
  // zero, so the signed multiplier still yields the unsigned product.
  logic [16:0] lane16_a [2];
  logic [16:0] lane16_b [2];
  logic [16:0] lane8_a  [4];
  logic [16:0] lane8_b  [4];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane16
    assign lane16_a[gi] = {signed_i & operand_a_i[16*gi+15], operand_a_i[16*gi +: 16]};
    assign lane16_b[gi] = {signed_i & operand_b_i[16*gi+15], operand_b_i[16*gi +: 16]};
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane8
    assign lane8_a[gi] = {{9{signed_i & operand_a_i[8*gi+7]}}, operand_a_i[8*gi +: 8]};
    assign lane8_b[gi] = {{9{signed_i & operand_b_i[8*gi+7]}}, operand_b_i[8*gi +: 8]};
  end

  logic [16:0] lane_a, lane_b;
  assign lane_a = is_dot8 ? lane8_a[cnt_q] : lane16_a[cnt_q[0]];
  assign lane_b = is_dot8 ? lane8_b[cnt_q] : lane16_b[cnt_q[0]];

  // Lane 0 is always issued from IDLE, so it seeds the sum from rd.
  // Every later lane continues from the running sum held in imd_val[0].
  logic [33:0] acc_base, dot_sum, mulh_val, lane_wdata;
  assign acc_base = (state_q == IDLE) ? {{2{operand_rd_i[31]}}, operand_rd_i}
                                      : imd_val_q_i[0];
  assign dot_sum  = acc_base + mul_res_i;

  // MULH16 replaces the high half of the lane product in its own 16-bit
  // slot and keeps the rest of imd_val[0].
  always_comb begin
    mulh_val = imd_val_q_i[0];
    if (cnt_q[0]) begin
      mulh_val[31:16] = mul_res_i[31:16];
    end else begin
      mulh_val[15:0]  = mul_res_i[31:16];
    end
  end

`ifdef IBEX_SIMD_MUL_SAT_EN
  logic        sat_q, sat_d, sat_hit;
  logic [33:0] sat_clamp;

  // The sum is out of the 32-bit signed range when bits 33:31 disagree.
  assign sat_hit   = signed_i & ~is_dot8 & ~is_mulh & (state_q == CALC) & last_lane &
                     (dot_sum[33:31] != 3'b000) & (dot_sum[33:31] != 3'b111);
  assign sat_clamp = dot_sum[33] ? 34'h3_8000_0000 : 34'h0_7FFF_FFFF;
  assign lane_wdata = is_mulh ? mulh_val : (sat_hit ? sat_clamp : dot_sum);

  // The saturation flag is set when the last lane clamps and is cleared on
  // IDLE or on a kill.
  always_comb begin
    sat_d = sat_q;
    case (state_q)
      IDLE: sat_d = 1'b0;
      CALC: begin
        if (!en_i) begin
          sat_d = 1'b0;
        end else if (sat_hit) begin
          sat_d = 1'b1;
        end
      end
      default: sat_d = sat_q;
    endcase
  end

  // Saturation flag register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q & valid_int;
`else
  assign lane_wdata = is_mulh ? mulh_val : dot_sum;
  assign sat_o      = 1'b0;
`endif

  // Sequencer next state and outputs. Reset forces all outputs to zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we0        = 1'b0;
    valid_int  = 1'b0;
    result_int = 32'h0;
    drive_ops  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          drive_ops = 1'b1;
          we0       = 1'b1;
          cnt_d     = 2'd1;
          state_d   = CALC;
        end
      end
      CALC: begin
        drive_ops = 1'b1;
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          we0   = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (last_lane) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          valid_int  = 1'b1;
          result_int = imd_val_q_i[0][31:0];
          if (ready_id_i) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    if (!rst_ni) begin
      we0        = 1'b0;
      valid_int  = 1'b0;
      result_int = 32'h0;
      drive_ops  = 1'b0;
    end
  end

  // State and lane counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_op_a_o     = drive_ops ? lane_a : 17'h0;
  assign mul_op_b_o     = drive_ops ? lane_b : 17'h0;
  assign imd_val_d_o[0] = lane_wdata;
  assign imd_val_d_o[1] = imd_val_q_i[1];
  assign imd_val_we_o   = {1'b0, we0};
  assign result_o       = result_int;
  assign valid_o        = valid_int;

endmodule

// File: tb/tb_ibex_simd_mul_seq.sv
// tb_ibex_simd_mul_seq: surrounds the sequencer with a behavioural multiplier
// and an imd_val register. Each operation is compared with an arithmetic
// model of the DOT/MULH rules.
module tb_ibex_simd_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, sg, ready;
  logic [1:0]  op;
  logic [31:0] a, b, rd;
  logic [16:0] mop_a, mop_b;
  logic [33:0] mres;
  logic [33:0] imd_q [2] = '{34'h0, 34'h0};
  logic [33:0] imd_d [2];
  logic [1:0]  imd_we;
  logic [31:0] result;
  logic        valid, sat;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_result;
  logic        last_sat;

  always #5 clk = ~clk;

  ibex_simd_mul_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .op_i         (op),
    .signed_i     (sg),
    .operand_a_i  (a),
    .operand_b_i  (b),
    .operand_rd_i (rd),
    .ready_id_i   (ready),
    .mul_op_a_o   (mop_a),
    .mul_op_b_o   (mop_b),
    .mul_res_i    (mres),
    .imd_val_q_i  (imd_q),
    .imd_val_d_o  (imd_d),
    .imd_val_we_o (imd_we),
    .result_o     (result),
    .valid_o      (valid),
    .sat_o        (sat)
  );

  // Shared 17x17 signed multiplier
  logic signed [33:0] pa, pb;
  assign pa   = {{17{mop_a[16]}}, mop_a};
  assign pb   = {{17{mop_b[16]}}, mop_b};
  assign mres = pa * pb;

  // EX-stage imd_val registers
  always @(posedge clk) begin
    if (imd_we[0]) imd_q[0] <= imd_d[0];
    if (imd_we[1]) imd_q[1] <= imd_d[1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Numeric value of lane k of x, as an 8-bit or 16-bit, signed or unsigned integer
  function automatic longint lane_val(input logic [31:0] x, input int k, input bit b8, input bit s);
    logic [15:0] v16;
    logic [7:0]  v8;
    if (b8) begin
      v8 = x[8*k +: 8];
      return s ? longint'($signed(v8)) : longint'(v8);
    end
    v16 = x[16*k +: 16];
    return s ? longint'($signed(v16)) : longint'(v16);
  endfunction

  // Reference: DOT = rd + sum(a_k*b_k) mod 2^32; MULH16 = per-lane product bits 31:16
  function automatic void model(input logic [1:0] o, input bit s, input logic [31:0] ia,
                                input logic [31:0] ib, input logic [31:0] ird,
                                output logic [31:0] res, output bit sat_e);
    longint      acc, p, lim;
    logic [63:0] pu;
    bit          b8;
    int          n;
    b8    = (o == 2'b01);
    n     = b8 ? 4 : 2;
    sat_e = 1'b0;
    res   = 32'h0;
    lim   = 64'sd2147483648;
    if (o == 2'b10) begin
      for (int k = 0; k < 2; k++) begin
        p  = lane_val(ia, k, 1'b0, s) * lane_val(ib, k, 1'b0, s);
        pu = p;
        res[16*k +: 16] = pu[31:16];
      end
    end else begin
      acc = longint'($signed(ird));
      for (int k = 0; k < n; k++) begin
        acc += lane_val(ia, k, b8, s) * lane_val(ib, k, b8, s);
      end
      pu  = acc;
      res = pu[31:0];
`ifdef IBEX_SIMD_MUL_SAT_EN
      if (s && !b8) begin
        if (acc >= lim) begin
          res = 32'h7FFF_FFFF; sat_e = 1'b1;
        end else if (acc < -lim) begin
          res = 32'h8000_0000; sat_e = 1'b1;
        end
      end
`endif
    end
  endfunction

  // One full operation: issue, follow each lane, check the result, hold in FINISH, release to IDLE
  task automatic run_op(input logic [1:0] o, input bit s, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] ird, input int hold);
    logic [31:0] eres;
    bit          esat, seen;
    int          n, cyc;
    longint      lv;
    logic [63:0] lu;
    model(o, s, ia, ib, ird, eres, esat);
    n = (o == 2'b01) ? 4 : 2;
    @(posedge clk); #1;
    en = 1'b1; op = o; sg = s; a = ia; b = ib; rd = ird; ready = (hold == 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < n + 4) begin
      cyc++;
      @(negedge clk);
      if (cyc <= n) begin
        lv = lane_val(ia, cyc - 1, o == 2'b01, s); lu = lv;
        check("lane_op_a", 64'(mop_a), 64'(lu[16:0]));
        lv = lane_val(ib, cyc - 1, o == 2'b01, s); lu = lv;
        check("lane_op_b", 64'(mop_b), 64'(lu[16:0]));
        check("lane_we", 64'(imd_we), 64'd1);
      end
      if (valid) begin
        seen = 1'b1;
        check("latency", 64'(cyc), 64'(n + 1));
        check("result", 64'(result), 64'(eres));
        check("sat", 64'(sat), 64'(esat));
        check("finish_we", 64'(imd_we), 64'd0);
        check("finish_op_a", 64'(mop_a), 64'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) check("valid_timeout", 64'd0, 64'd1);
    last_result = result;
    last_sat    = sat;
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", 64'(valid), 64'd1);
      check("hold_result", 64'(result), 64'(eres));
      check("hold_we", 64'(imd_we), 64'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      ready = 1'b1;
      @(negedge clk);
      check("release_valid", 64'(valid), 64'd1);
    end
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("idle_valid", 64'(valid), 64'd0);
    check("idle_result", 64'(result), 64'd0);
    check("idle_op_a", 64'(mop_a), 64'd0);
    $display("op=%0d signed=%0d a=%h b=%h rd=%h result=%h sat=%0d", o, s, ia, ib, ird, last_result, last_sat);
  endtask

  initial begin
    logic [31:0] sat_exp;
    logic        sat_flag_exp;
    rst_n = 1'b0; en = 1'b0; sg = 1'b0; ready = 1'b1; op = 2'b00;
    a = 32'h0; b = 32'h0; rd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_we", 64'(imd_we), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_we", 64'(imd_we), 64'd0);
    check("idle_op_b", 64'(mop_b), 64'd0);
    check("idle_sat", 64'(sat), 64'd0);

    // Directed cases with known answers
    run_op(2'b00, 1'b1, 32'h0003_FFFE, 32'h0004_0005, 32'd10, 0);
    check("dot16_known", 64'(last_result), 64'h0000_000C);
    run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
    check("dot8_known", 64'(last_result), 64'h0003_F804);
    run_op(2'b10, 1'b1, 32'h8000_7FFF, 32'h8000_7FFF, 32'h1234_5678, 0);
    check("mulh16_known", 64'(last_result), 64'h4000_3FFF);
    run_op(2'b11, 1'b1, 32'h0003_FFFE, 32'h0004_0005, 32'd10, 0);
    check("reserved_op", 64'(last_result), 64'h0000_000C);
    run_op(2'b00, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0100, 4);

`ifdef IBEX_SIMD_MUL_SAT_EN
    sat_exp = 32'h7FFF_FFFF; sat_flag_exp = 1'b1;
`else
    sat_exp = 32'hFFFF_FFFF; sat_flag_exp = 1'b0;
`endif
    run_op(2'b00, 1'b1, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 0);
    check("sat_result", 64'(last_result), 64'(sat_exp));
    check("sat_flag", 64'(last_sat), 64'(sat_flag_exp));

    // Kill DOT8 at lane 2
    @(posedge clk); #1;
    en = 1'b1; op = 2'b01; sg = 1'b0; a = 32'h0102_0304; b = 32'h0506_0708; rd = 32'h0; ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("kill_we", 64'(imd_we), 64'd0);
    check("kill_valid", 64'(valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_kill_valid", 64'(valid), 64'd0);
    check("post_kill_op_a", 64'(mop_a), 64'd0);
    run_op(2'b00, 1'b1, 32'h0011_0022, 32'hFFF0_0003, 32'h0000_0040, 0);

    // Synchronous reset in CALC
    @(posedge clk); #1;
    en = 1'b1; op = 2'b01; sg = 1'b1; a = 32'h7F7F_7F7F; b = 32'h0303_0303; rd = 32'h5;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);
    check("rst_calc_valid", 64'(valid), 64'd0);
    check("rst_calc_result", 64'(result), 64'd0);
    check("rst_calc_we", 64'(imd_we), 64'd0);
    check("rst_calc_op_a", 64'(mop_a), 64'd0);
    check("rst_calc_op_b", 64'(mop_b), 64'd0);
    check("rst_calc_sat", 64'(sat), 64'd0);
    run_op(2'b00, 1'b1, 32'h0003_FFFE, 32'h0004_0005, 32'd10, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
